// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start + LSB-first data + optional parity + one stop bit
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [7:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Done
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_n;
    logic [7:0]            cnt_q, cnt_n, p_q, p_n;
    logic [3:0]            bit_q, bit_n;
    logic [DATA_WIDTH-1:0] data_q, data_n, dsh;
    logic                  par_en_q, par_en_n, par_typ_q, par_typ_n;
    logic                  tx_n, done_n, last;

    assign last = cnt_q == p_q;

    // next state, counters and latches; TX_OUT is precomputed from the next state so it can be registered
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q + 8'd1;
        bit_n     = bit_q;
        data_n    = data_q;
        p_n       = p_q;
        par_en_n  = par_en_q;
        par_typ_n = par_typ_q;
        done_n    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = 8'd0;
                bit_n = 4'd0;
                if (Data_Valid) begin
                    state_n   = START;
                    cnt_n     = 8'd1;
                    data_n    = P_DATA;
                    p_n       = (Prescale == 8'd0) ? 8'd1 : Prescale;
                    par_en_n  = PAR_EN;
                    par_typ_n = PAR_TYP;
                end
            end
            START: if (last) begin
                state_n = DATA;
                cnt_n   = 8'd1;
            end
            DATA: if (last) begin
                cnt_n = 8'd1;
                if (bit_q == LAST_BIT) state_n = par_en_q ? PARITY : STOP;
                else bit_n = bit_q + 4'd1;
            end
            PARITY: if (last) begin
                state_n = STOP;
                cnt_n   = 8'd1;
            end
            STOP: if (last) begin
                state_n = IDLE;
                cnt_n   = 8'd0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        dsh  = data_n >> bit_n;
        tx_n = (state_n == START)  ? 1'b0 :
               (state_n == DATA)   ? dsh[0] :
               (state_n == PARITY) ? (^data_n) ^ par_typ_n : 1'b1;
    end

    // state, latches and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 4'd0;
            data_q    <= '0;
            p_q       <= 8'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            data_q    <= data_n;
            p_q       <= p_n;
            par_en_q  <= par_en_n;
            par_typ_q <= par_typ_n;
            TX_OUT    <= tx_n;
            Busy      <= state_n != IDLE;
            Done      <= done_n;
        end
    end
endmodule
